// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-output FIFO and sends each one as an 8N1 UART frame.
// Every output is a flop whose value is decoded from the next state.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   output logic       fifo_rd_en,
   input  logic [7:0] fifo_rd_data,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);
   // state   | meaning
   // S_IDLE  | line high, waiting for enable with data available
   // S_POP   | one-cycle read strobe to the FIFO
   // S_LATCH | FIFO data_out valid, loaded into the shift register
   // S_START | start bit (tx low) for one bit period
   // S_DATA  | eight data bits, LSB first
   // S_STOP  | stop bit (tx high), frame_done on its last cycle
   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LATCH, S_START, S_DATA, S_STOP
   } state_t;

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   state_t        state, state_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          tx_nxt, busy_nxt, rd_en_nxt, done_nxt;
   logic          baud_end;

   assign baud_end = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_cnt;
      baud_nxt  = baud_cnt;
      shreg_nxt = shreg;
      case (state)
         S_IDLE: begin
            if (enable && !fifo_empty) state_nxt = S_POP;
         end
         S_POP: begin
            state_nxt = S_LATCH;
         end
         S_LATCH: begin
            shreg_nxt = fifo_rd_data;
            baud_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = S_START;
         end
         S_START: begin
            if (baud_end) begin
               baud_nxt  = '0;
               state_nxt = S_DATA;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_nxt  = '0;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) begin
                  bit_nxt   = '0;
                  state_nxt = S_STOP;
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_nxt  = '0;
               state_nxt = S_IDLE;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the flops below line up with the state they describe.
      tx_nxt    = 1'b1;
      if (state_nxt == S_START) tx_nxt = 1'b0;
      if (state_nxt == S_DATA)  tx_nxt = shreg_nxt[0];
      busy_nxt  = (state_nxt != S_IDLE);
      rd_en_nxt = (state_nxt == S_POP);
      done_nxt  = (state_nxt == S_STOP) && (baud_nxt == BAUD_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         baud_cnt   <= '0;
         shreg      <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         fifo_rd_en <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_nxt;
         baud_cnt   <= baud_nxt;
         shreg      <= shreg_nxt;
         tx         <= tx_nxt;
         busy       <= busy_nxt;
         fifo_rd_en <= rd_en_nxt;
         frame_done <= done_nxt;
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: CLKS_PER_BIT=4 instance with a small FIFO model, plus 2 and 16 instances for baud scaling.
module tb_fifo_uart_tx;
   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_seq;   // tx per bit period, first period in bit 9
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // CLKS_PER_BIT=4 instance fed from a registered-output FIFO model
   logic       en4 = 1'b0;
   logic       empty4, rd_en4, tx4, busy4, done4;
   logic [7:0] rd_data4 = 8'h00;
   logic [7:0] mem4 [0:15];
   int         wr4 = 0, rd4 = 0, rd_cyc4 = 0;
   assign empty4 = (wr4 == rd4);
   always @(posedge clk) if (rd_en4) begin
      rd_data4 <= mem4[rd4 % 16];
      rd4      <= rd4 + 1;
   end
   always @(negedge clk) if (rd_en4) rd_cyc4 <= cyc;

   fifo_uart_tx #(.CLKS_PER_BIT(4)) u4 (
      .clk(clk), .rst(rst), .enable(en4), .fifo_empty(empty4), .fifo_rd_en(rd_en4),
      .fifo_rd_data(rd_data4), .tx(tx4), .busy(busy4), .frame_done(done4));

   // CLKS_PER_BIT=2 and 16 instances, each offered 0x55 once per load
   logic       en2 = 1'b0, en16 = 1'b0;
   logic       empty2, rd_en2, tx2, busy2, done2;
   logic       empty16, rd_en16, tx16, busy16, done16;
   logic [7:0] byte55 = 8'h55;
   int         loads2 = 0, pops2 = 0, loads16 = 0, pops16 = 0;
   assign empty2  = (loads2 == pops2);
   assign empty16 = (loads16 == pops16);
   always @(posedge clk) begin
      if (rd_en2)  pops2  <= pops2 + 1;
      if (rd_en16) pops16 <= pops16 + 1;
   end

   fifo_uart_tx #(.CLKS_PER_BIT(2)) u2 (
      .clk(clk), .rst(rst), .enable(en2), .fifo_empty(empty2), .fifo_rd_en(rd_en2),
      .fifo_rd_data(byte55), .tx(tx2), .busy(busy2), .frame_done(done2));

   fifo_uart_tx #(.CLKS_PER_BIT(16)) u16 (
      .clk(clk), .rst(rst), .enable(en16), .fifo_empty(empty16), .fifo_rd_en(rd_en16),
      .fifo_rd_data(byte55), .tx(tx16), .busy(busy16), .frame_done(done16));

   function automatic logic txs(input int s);
      case (s)
         0:       return tx4;
         1:       return tx2;
         default: return tx16;
      endcase
   endfunction

   function automatic logic dones(input int s);
      case (s)
         0:       return done4;
         1:       return done2;
         default: return done16;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push4(input logic [7:0] d);
      mem4[wr4 % 16] = d;
      wr4++;
   endtask

   // Waits for the start bit, then samples mid-period and tracks frame_done across the frame.
   // Returns at the negedge of the last stop cycle. drop_at >= 0 clears en4 at that frame cycle.
   task automatic capture(input int s, input int drop_at, output logic [9:0] seq,
                          output int t0, output int fd_pos, output int fd_cnt);
      int cpb;
      int n;
      cpb    = (s == 0) ? 4 : (s == 1) ? 2 : 16;
      seq    = '1;
      t0     = -1000;
      fd_pos = -1;
      fd_cnt = 0;
      n      = 0;
      while (txs(s) !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (txs(s) !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL start_timeout dut%0d: tx=%b, required 0 within 500 cycles", s, txs(s));
         return;
      end
      t0 = cyc;
      for (int i = 0; i < 10 * cpb; i++) begin
         if (i % cpb == cpb / 2) seq[9 - i / cpb] = txs(s);
         if (dones(s) === 1'b1) begin
            fd_cnt++;
            if (fd_pos < 0) fd_pos = i;
         end
         if (i == drop_at) en4 = 1'b0;
         if (i < 10 * cpb - 1) @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vt [4];
      logic [9:0] seq;
      int         t0, fdp, fdc, p0, g, bad_tx, bad_busy, bad_rd;

      vt[0] = '{8'hA5, 10'b0101001011};
      vt[1] = '{8'h55, 10'b0101010101};
      vt[2] = '{8'h81, 10'b0100000011};
      vt[3] = '{8'h42, 10'b0010000101};

      repeat (3) @(negedge clk);
      chk("rst_tx", tx4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_rd_en", rd_en4, 0);
      chk("rst_frame_done", done4, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single frames at CLKS_PER_BIT=4
      for (int k = 0; k < 4; k++) begin
         p0 = rd4;
         push4(vt[k].data);
         en4 = 1'b1;
         capture(0, -1, seq, t0, fdp, fdc);
         chk($sformatf("vec%0d_seq", k), seq, vt[k].exp_seq);
         chk($sformatf("vec%0d_rd_to_start", k), t0 - rd_cyc4, 2);
         chk($sformatf("vec%0d_rd_to_done", k), t0 + fdp - rd_cyc4, 41);
         chk($sformatf("vec%0d_done_count", k), fdc, 1);
         @(negedge clk);
         en4 = 1'b0;
         repeat (3) @(negedge clk);
         chk($sformatf("vec%0d_pops", k), rd4 - p0, 1);
         chk($sformatf("vec%0d_idle_busy", k), busy4, 0);
      end

      // back-to-back 0x00, 0xFF, 0x3C
      p0 = rd4;
      push4(8'h00);
      push4(8'hFF);
      push4(8'h3C);
      en4 = 1'b1;
      capture(0, -1, seq, t0, fdp, fdc);
      chk("b2b0_seq", seq, 10'b0000000001);
      for (int j = 1; j < 3; j++) begin
         g = 0;
         @(negedge clk);
         while (tx4 === 1'b1 && g < 50) begin
            g++;
            @(negedge clk);
         end
         chk($sformatf("b2b%0d_gap", j), g, 3);
         capture(0, -1, seq, t0, fdp, fdc);
         chk($sformatf("b2b%0d_seq", j), seq, (j == 1) ? 10'b0111111111 : 10'b0001111001);
      end
      repeat (20) @(negedge clk);
      chk("b2b_pops", rd4 - p0, 3);
      en4 = 1'b0;

      // enable dropped during DATA of 0x81 with 0x42 queued
      p0 = rd4;
      push4(8'h81);
      push4(8'h42);
      en4 = 1'b1;
      capture(0, 13, seq, t0, fdp, fdc);
      chk("drop_seq_81", seq, 10'b0100000011);
      chk("drop_done_count", fdc, 1);
      repeat (30) @(negedge clk);
      chk("drop_pops_held", rd4 - p0, 1);
      chk("drop_idle_tx", tx4, 1);
      chk("drop_idle_busy", busy4, 0);
      en4 = 1'b1;
      capture(0, -1, seq, t0, fdp, fdc);
      chk("drop_seq_42", seq, 10'b0010000101);
      repeat (5) @(negedge clk);
      chk("drop_pops_total", rd4 - p0, 2);
      en4 = 1'b0;

      // empty FIFO with enable high
      en4 = 1'b1;
      bad_tx = 0; bad_busy = 0; bad_rd = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tx4 !== 1'b1)   bad_tx++;
         if (busy4 !== 1'b0) bad_busy++;
         if (rd_en4 !== 1'b0) bad_rd++;
      end
      chk("empty_rd_en_cycles", bad_rd, 0);
      chk("empty_tx_low_cycles", bad_tx, 0);
      chk("empty_busy_cycles", bad_busy, 0);

      // reset in the middle of DATA
      p0 = rd4;
      push4(8'hA5);
      g = 0;
      while (tx4 !== 1'b0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      repeat (10) @(negedge clk);
      chk("pre_rst_tx_data", tx4, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx", tx4, 1);
      chk("midrst_busy", busy4, 0);
      chk("midrst_rd_en", rd_en4, 0);
      @(negedge clk);
      rst = 1'b0;
      bad_tx = 0; bad_rd = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx4 !== 1'b1)    bad_tx++;
         if (rd_en4 !== 1'b0) bad_rd++;
      end
      chk("postrst_tx_low_cycles", bad_tx, 0);
      chk("postrst_rd_en_cycles", bad_rd, 0);
      chk("postrst_pops", rd4 - p0, 1);
      en4 = 1'b0;

      // baud scaling with 0x55
      en2 = 1'b1;
      loads2 = loads2 + 1;
      capture(1, -1, seq, t0, fdp, fdc);
      chk("cpb2_seq", seq, 10'b0101010101);
      chk("cpb2_frame_len", fdp + 1, 20);
      chk("cpb2_done_count", fdc, 1);
      en2 = 1'b0;
      en16 = 1'b1;
      loads16 = loads16 + 1;
      capture(2, -1, seq, t0, fdp, fdc);
      chk("cpb16_seq", seq, 10'b0101010101);
      chk("cpb16_frame_len", fdp + 1, 160);
      chk("cpb16_done_count", fdc, 1);
      en16 = 1'b0;
      repeat (5) @(negedge clk);
      chk("cpb2_pops", pops2, 1);
      chk("cpb16_pops", pops16, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
